// File: rtl/cic_decimator_pkg.sv
// Shared DDC constants and the ratio-to-shift lookup for the CIC decimator.
package cic_decimator_pkg;

   localparam int unsigned CIC_N_STAGES = 4;
   localparam int unsigned CIC_IN_W     = 18;
   // Integrator headroom: 8 bits per stage covers R up to 256.
   localparam int unsigned CIC_ACC_W    = CIC_IN_W + 8 * CIC_N_STAGES;

   // ceil(log2(R)) with R = code+1; code 0 behaves as code 1 (R = 2).
   // For code >= 1 this is simply the bit length of the code.
   function automatic logic [3:0] clog2_ratio(input logic [7:0] code);
      logic [3:0] n;
      n = 4'd1;
      for (int b = 0; b < 8; b++) begin
         if (code[b]) n = 4'(b + 1);
      end
      return n;
   endfunction

endpackage

// File: rtl/cic_decimator_channel.sv
// One CIC datapath: pipelined integrators, strobed comb chain and the
// round-half-up scaler. All sequencing comes from the parent.
module cic_channel
   import cic_decimator_pkg::*;
#(
   parameter int unsigned N_STAGES = CIC_N_STAGES,
   parameter int unsigned IN_W     = CIC_IN_W,
   parameter int unsigned ACC_W    = CIC_ACC_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   clear,
   input  logic [N_STAGES-1:0]    adv,
   input  logic signed [IN_W-1:0] din,
   input  logic [7:0]             shift,
   output logic signed [IN_W-1:0] dout
);

   logic signed [ACC_W-1:0] integ   [N_STAGES];
   logic signed [ACC_W-1:0] comb    [N_STAGES];
   logic signed [ACC_W-1:0] prev    [N_STAGES];
   logic signed [ACC_W-1:0] comb_in [N_STAGES];
   logic signed [ACC_W-1:0] half;
   logic signed [ACC_W-1:0] rnd;

   // Integrator cascade; each stage adds the previous stage's register (wraps freely).
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < int'(N_STAGES); k++) integ[k] <= '0;
      end else if (en) begin
         integ[0] <= integ[0] + ACC_W'(din);
         for (int k = 1; k < int'(N_STAGES); k++) integ[k] <= integ[k] + integ[k-1];
      end
   end

   // Comb inputs: the last integrator feeds stage 0, each stage feeds the next.
   always_comb begin
      comb_in[0] = integ[N_STAGES-1];
      for (int k = 1; k < int'(N_STAGES); k++) comb_in[k] = comb[k-1];
   end

   // Comb stages, each advancing on its own strobe; clear wipes the delay line.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         for (int k = 0; k < int'(N_STAGES); k++) begin
            comb[k] <= '0;
            prev[k] <= '0;
         end
      end else begin
         for (int k = 0; k < int'(N_STAGES); k++) begin
            if (adv[k]) begin
               comb[k] <= comb_in[k] - prev[k];
               prev[k] <= comb_in[k];
            end
         end
      end
   end

   // Round half-up then arithmetic shift; the result always fits in IN_W.
   always_comb begin
      half = ACC_W'(1) << (shift - 8'd1);
      rnd  = comb[N_STAGES-1] + half;
      dout = IN_W'(rnd >>> shift);
   end

endmodule

// File: rtl/cic_decimator.sv
// I/Q CIC decimator: decimation counter, comb strobes, settling after
// ratio or mode changes, and the bypass path around two CIC channels.
module cic_decimator
   import cic_decimator_pkg::*;
#(
   parameter int unsigned N_STAGES = CIC_N_STAGES,
   parameter int unsigned IN_W     = CIC_IN_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clkEn,
   input  logic signed [IN_W-1:0] iIn,
   input  logic signed [IN_W-1:0] qIn,
   input  logic                   bypassCic,
   input  logic [7:0]             adcDecimation,
   output logic signed [IN_W-1:0] iOut,
   output logic signed [IN_W-1:0] qOut,
   output logic                   outValid
);

   localparam int unsigned ACC_W = IN_W + 8 * N_STAGES;
   localparam int unsigned SW    = $clog2(N_STAGES + 1);

   logic                   bypass_q;
   logic [7:0]             dec_q;
   logic [7:0]             count_q;
   logic [N_STAGES-1:0]    stb_q;
   logic [SW-1:0]          settle_q;
   logic [7:0]             code_eff;
   logic [7:0]             shift;
   logic                   ratio_change;
   logic                   cic_en;
   logic                   tap;
   logic [N_STAGES-1:0]    adv;
   logic signed [IN_W-1:0] i_round;
   logic signed [IN_W-1:0] q_round;

   // Control decode from the registered configuration.
   always_comb begin
      code_eff     = (dec_q == 8'd0) ? 8'd1 : dec_q;
      shift        = 8'(N_STAGES * int'(clog2_ratio(dec_q)));
      // A bypass exit restarts decimation exactly like a new ratio.
      ratio_change = (adcDecimation != dec_q) || (bypass_q && !bypassCic);
      cic_en       = clkEn && !bypass_q;
      tap          = cic_en && (count_q == code_eff) && !ratio_change;
      adv[0]       = tap;
      for (int k = 1; k < int'(N_STAGES); k++) adv[k] = stb_q[k-1];
   end

   // Counter, strobe pipeline, settling and output registers.
   always_ff @(posedge clk) begin
      bypass_q <= bypassCic;
      dec_q    <= adcDecimation;
      if (reset) begin
         count_q  <= '0;
         stb_q    <= '0;
         settle_q <= SW'(N_STAGES);
         iOut     <= '0;
         qOut     <= '0;
         outValid <= 1'b0;
      end else begin
         outValid <= 1'b0;
         stb_q    <= (stb_q << 1) | N_STAGES'(tap);
         if (ratio_change) begin
            count_q  <= '0;
            stb_q    <= '0;
            settle_q <= SW'(N_STAGES);
         end else if (cic_en) begin
            count_q <= (count_q == code_eff) ? 8'd0 : count_q + 8'd1;
         end
         if (bypass_q) begin
            if (clkEn) begin
               iOut     <= iIn;
               qOut     <= qIn;
               outValid <= 1'b1;
            end
         end else if (stb_q[N_STAGES-1] && !ratio_change) begin
            // The first N_STAGES results after a restart see cleared comb delays.
            if (settle_q != '0) begin
               settle_q <= settle_q - SW'(1);
            end else begin
               iOut     <= i_round;
               qOut     <= q_round;
               outValid <= 1'b1;
            end
         end
      end
   end

   cic_channel #(
      .N_STAGES(N_STAGES),
      .IN_W    (IN_W),
      .ACC_W   (ACC_W)
   ) u_chan_i (
      .clk  (clk),
      .reset(reset),
      .en   (cic_en),
      .clear(ratio_change),
      .adv  (adv),
      .din  (iIn),
      .shift(shift),
      .dout (i_round)
   );

   cic_channel #(
      .N_STAGES(N_STAGES),
      .IN_W    (IN_W),
      .ACC_W   (ACC_W)
   ) u_chan_q (
      .clk  (clk),
      .reset(reset),
      .en   (cic_en),
      .clear(ratio_change),
      .adv  (adv),
      .din  (qIn),
      .shift(shift),
      .dout (q_round)
   );

endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator: the reference computes each decimated
// output as an FIR (boxcar convolved N times) over all samples since reset.
module tb_cic_decimator;
   import cic_decimator_pkg::*;

   localparam int N = CIC_N_STAGES;
   localparam int W = CIC_IN_W;

   logic                clk = 1'b0;
   logic                reset;
   logic                clkEn;
   logic signed [W-1:0] iIn;
   logic signed [W-1:0] qIn;
   logic                bypassCic;
   logic [7:0]          adcDecimation;
   logic signed [W-1:0] iOut;
   logic signed [W-1:0] qOut;
   logic                outValid;

   cic_decimator #(
      .N_STAGES(N),
      .IN_W    (W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .clkEn        (clkEn),
      .iIn          (iIn),
      .qIn          (qIn),
      .bypassCic    (bypassCic),
      .adcDecimation(adcDecimation),
      .iOut         (iOut),
      .qOut         (qOut),
      .outValid     (outValid)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint i;
      longint q;
      longint due;
   } exp_t;

   exp_t   sb[$];
   longint hist_i[$];
   longint hist_q[$];
   longint h[];
   longint cyc = 0;
   int     ratio;
   int     shift_s;
   int     since_tap;
   int     settle;
   int     cur_code;
   bit     cur_byp;
   int     checks = 0;
   int     errors = 0;
   int     n_out = 0;
   int     base;
   longint last_i = 0;
   longint last_q = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Ratio R, scale S and the impulse response for a decimation code.
   task automatic model_config(input int code);
      longint tmp[];
      int c;
      ratio = (code == 0) ? 2 : code + 1;
      c = 0;
      while ((1 << c) < ratio) c++;
      shift_s = N * c;
      h = new[1];
      h[0] = 1;
      for (int s = 0; s < N; s++) begin
         tmp = new[h.size() + ratio - 1];
         foreach (tmp[k]) tmp[k] = 0;
         for (int a = 0; a < h.size(); a++)
            for (int b = 0; b < ratio; b++) tmp[a+b] += h[a];
         h = tmp;
      end
      since_tap = 0;
      settle    = N;
   endtask

   // Filter output at the newest sample; the integrator pipeline delays by N samples.
   function automatic longint fir(input bit use_q);
      longint acc;
      int     n;
      int     idx;
      acc = 0;
      n   = hist_i.size() - 1;
      for (int k = 0; k < h.size(); k++) begin
         idx = n - N - k;
         if (idx >= 0) acc += h[k] * (use_q ? hist_q[idx] : hist_i[idx]);
      end
      return acc;
   endfunction

   function automatic longint scale(input longint y);
      longint              r;
      logic signed [W-1:0] t;
      r = (y + (longint'(1) <<< (shift_s - 1))) >>> shift_s;
      t = r[W-1:0];
      return longint'(t);
   endfunction

   function automatic longint rnd_sample();
      return longint'($urandom_range(0, 262143)) - 131072;
   endfunction

   // Drive one cycle and predict any resulting output.
   task automatic send(input bit en, input longint xi, input longint xq);
      @(negedge clk);
      clkEn = en;
      iIn   = W'(xi);
      qIn   = W'(xq);
      if (en) begin
         if (bypassCic) begin
            sb.push_back('{xi, xq, cyc + 1});
         end else begin
            hist_i.push_back(xi);
            hist_q.push_back(xq);
            since_tap++;
            if (since_tap == ratio) begin
               since_tap = 0;
               if (settle > 0) settle--;
               else sb.push_back('{scale(fir(1'b0)), scale(fir(1'b1)), cyc + 1 + N});
            end
         end
      end
   endtask

   task automatic drain();
      repeat (N + 3) send(1'b0, 0, 0);
   endtask

   task automatic reconfig(input int code, input bit byp);
      drain();
      @(negedge clk);
      clkEn = 1'b0;
      if (code != cur_code || (cur_byp && !byp)) model_config(code);
      adcDecimation = 8'(code);
      bypassCic     = byp;
      cur_code      = code;
      cur_byp       = byp;
      repeat (2) send(1'b0, 0, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      clkEn = 1'b0;
      sb.delete();
      hist_i.delete();
      hist_q.delete();
      model_config(cur_code);
      @(posedge clk);
      #1;
      check("rst_outValid", longint'(outValid), 0);
      check("rst_iOut", iOut, 0);
      check("rst_qOut", qOut, 0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Monitor: compare every presented output against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (outValid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: got iOut=%0d qOut=%0d, expected no output (cycle %0d)",
                        iOut, qOut, cyc);
            end else begin
               e = sb.pop_front();
               check("out_time", cyc, e.due);
               check("iOut", iOut, e.i);
               check("qOut", qOut, e.q);
            end
            last_i = iOut;
            last_q = qOut;
            n_out++;
         end else if (sb.size() > 0 && sb[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_valid: got no output, expected iOut=%0d at cycle %0d", sb[0].i,
                     sb[0].due);
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      #5_000_000;
      errors++;
      $display("FAIL watchdog: got time limit, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  code;
      bit  byp;
      reset         = 1'b1;
      clkEn         = 1'b0;
      iIn           = '0;
      qIn           = '0;
      bypassCic     = 1'b0;
      adcDecimation = 8'd3;
      cur_code      = 3;
      cur_byp       = 1'b0;
      model_config(3);
      do_reset();

      // DC +/-1000 at R=4, clkEn every cycle.
      base = n_out;
      repeat (32) send(1'b1, 1000, -1000);
      drain();
      check("dc_r4_count", n_out - base, 4);
      check("dc_r4_i", last_i, 1000);
      check("dc_r4_q", last_q, -1000);

      // R=3: gain 81, shift 8.
      reconfig(2, 1'b0);
      repeat (60) send(1'b1, 1000, -1000);
      drain();
      check("dc_r3_i", last_i, 316);
      check("dc_r3_q", last_q, -316);

      // Ratio change 4 -> 8 mid-stream: four results suppressed.
      reconfig(3, 1'b0);
      repeat (40) send(1'b1, 1000, -1000);
      reconfig(7, 1'b0);
      base = n_out;
      repeat (64) send(1'b1, 1000, -1000);
      drain();
      check("chg_r8_count", n_out - base, 4);
      check("chg_r8_i", last_i, 1000);

      // Bypass with a ramp on every third cycle.
      reconfig(7, 1'b1);
      for (int k = 0; k < 20; k++) begin
         send(1'b1, k, -k);
         send(1'b0, 0, 0);
         send(1'b0, 0, 0);
      end
      drain();
      check("bypass_last_i", last_i, 19);
      reconfig(7, 1'b0);

      // Full-scale DC at R=256, both polarities.
      reconfig(255, 1'b0);
      repeat (1536) send(1'b1, 131071, -131072);
      drain();
      check("fs_pos_i", last_i, 131071);
      check("fs_neg_q", last_q, -131072);
      repeat (1536) send(1'b1, -131072, 131071);
      drain();
      check("fs_neg_i", last_i, -131072);
      check("fs_pos_q", last_q, 131071);

      // Randomized ratios, gaps and occasional bypass.
      for (int rd = 0; rd < 12; rd++) begin
         code = $urandom_range(0, 9);
         byp  = ($urandom_range(0, 4) == 0);
         reconfig(code, byp);
         for (int s = 0; s < 80; s++) begin
            if ($urandom_range(0, 3) == 0) send(1'b0, 0, 0);
            else send(1'b1, rnd_sample(), rnd_sample());
         end
      end

      // Reset mid-frame; first result only after N+1 counter wraps.
      reconfig(3, 1'b0);
      repeat (10) send(1'b1, rnd_sample(), rnd_sample());
      do_reset();
      base = n_out;
      repeat ((N + 1) * 4 - 1) send(1'b1, rnd_sample(), rnd_sample());
      drain();
      check("post_rst_none", n_out - base, 0);
      send(1'b1, rnd_sample(), rnd_sample());
      drain();
      check("post_rst_first", n_out - base, 1);

      drain();
      check("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
